fb_arbiter: RTL and testbench

- Shares the single-port 320x240x3-bit framebuffer RAM between three requesters: video scanout (read-only), game logic (read/write) and a built-in full-screen clear engine.
- Video scanout normally has priority. A starvation counter guarantees the game logic a slot.
- Sits between game_logic, the VGA scanout and the RAM. It replaces game_logic's direct ram_* connection, and the clear engine takes over the RESET-state screen sweep.

---
 rtl/fb_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_fb_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter for video scanout, game logic and a full-screen clear engine.
// Grant is combinational, RAM access one cycle later, read data RD_LATENCY after that; losers are held off by ack.
module fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 3,
  parameter int FB_WORDS   = 76800,
  parameter int RD_LATENCY = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              gl_req,
  input  logic              gl_we,
  input  logic [ADDR_W-1:0] gl_addr,
  input  logic [DATA_W-1:0] gl_wdata,
  output logic              gl_ack,
  output logic              gl_rvalid,
  output logic [DATA_W-1:0] gl_rdata,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write_enabled,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data
);

  localparam int STARVE_W = $clog2(MAX_STARVE + 1);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_WORDS - 1);

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_CLEAR,
    CLR_DONE
  } clr_state_t;

  clr_state_t          clr_state;
  logic [ADDR_W-1:0]   clr_addr;
  logic [DATA_W-1:0]   clr_fill;
  logic [STARVE_W-1:0] starve;
  logic                vid_win;
  logic                gl_win;
  logic                clr_win;
  logic                gl_force;
  logic                rd_push;
  logic                rd_is_gl;
  logic [RD_LATENCY:0] tag_vld;
  logic [RD_LATENCY:0] tag_gl;
  logic [DATA_W-1:0]   vid_rdata_q;
  logic [DATA_W-1:0]   gl_rdata_q;

  always_comb begin
    gl_force = gl_req && (starve == STARVE_W'(MAX_STARVE));
    vid_win  = 1'b0;
    gl_win   = 1'b0;
    clr_win  = 1'b0;
    if (gl_force) begin
      gl_win = 1'b1;
    end else if (vid_req) begin
      vid_win = 1'b1;
    end else if (gl_req) begin
      gl_win = 1'b1;
    end else if (clr_state == CLR_CLEAR) begin
      clr_win = 1'b1;
    end
  end

  // Acks are masked while reset is held so every output reads 0 during reset.
  assign vid_ack = vid_win && reset;
  assign gl_ack  = gl_win && reset;

  assign rd_push  = vid_win || (gl_win && !gl_we);
  assign rd_is_gl = gl_win && !gl_we;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve <= '0;
    end else if (gl_req && !gl_win) begin
      if (starve != STARVE_W'(MAX_STARVE)) begin
        starve <= starve + STARVE_W'(1);
      end
    end else begin
      starve <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ram_address       <= '0;
      ram_write_enabled <= 1'b0;
      ram_write_data    <= '0;
    end else if (vid_win) begin
      ram_address       <= vid_addr;
      ram_write_enabled <= 1'b0;
    end else if (gl_win) begin
      ram_address       <= gl_addr;
      ram_write_enabled <= gl_we;
      if (gl_we) begin
        ram_write_data <= gl_wdata;
      end
    end else if (clr_win) begin
      ram_address       <= clr_addr;
      ram_write_enabled <= 1'b1;
      ram_write_data    <= clr_fill;
    end else begin
      ram_write_enabled <= 1'b0;
    end
  end

  // Stage k holds the read issued k+1 cycles ago; the last stage lines up with RAM data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_vld <= '0;
      tag_gl  <= '0;
    end else begin
      tag_vld[0] <= rd_push;
      tag_gl[0]  <= rd_is_gl;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_gl[i]  <= tag_gl[i-1];
      end
    end
  end

  assign vid_rvalid = tag_vld[RD_LATENCY] && !tag_gl[RD_LATENCY];
  assign gl_rvalid  = tag_vld[RD_LATENCY] && tag_gl[RD_LATENCY];
  assign vid_rdata  = vid_rvalid ? ram_read_data : vid_rdata_q;
  assign gl_rdata   = gl_rvalid ? ram_read_data : gl_rdata_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vid_rdata_q <= '0;
      gl_rdata_q  <= '0;
    end else begin
      if (vid_rvalid) begin
        vid_rdata_q <= ram_read_data;
      end
      if (gl_rvalid) begin
        gl_rdata_q <= ram_read_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clr_state <= CLR_IDLE;
      clr_addr  <= '0;
      clr_fill  <= '0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      case (clr_state)
        CLR_IDLE: begin
          clr_done <= 1'b0;
          if (clr_start) begin
            clr_fill  <= clr_color;
            clr_addr  <= '0;
            clr_busy  <= 1'b1;
            clr_state <= CLR_CLEAR;
          end
        end
        CLR_CLEAR: begin
          // Progress only on cycles the engine actually owns the RAM.
          if (clr_win) begin
            if (clr_addr == CLR_LAST) begin
              clr_busy  <= 1'b0;
              clr_done  <= 1'b1;
              clr_state <= CLR_DONE;
            end else begin
              clr_addr <= clr_addr + ADDR_W'(1);
            end
          end
        end
        CLR_DONE: begin
          clr_done  <= 1'b0;
          clr_state <= CLR_IDLE;
        end
        default: begin
          clr_busy  <= 1'b0;
          clr_done  <= 1'b0;
          clr_state <= CLR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: vector table for arbitration/read return, sequences for clear and reset.
module tb_fb_arbiter;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 3;
  localparam int FB_WORDS = 76800;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              vid_ack;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              gl_req = 1'b0;
  logic              gl_we = 1'b0;
  logic [ADDR_W-1:0] gl_addr = '0;
  logic [DATA_W-1:0] gl_wdata = '0;
  logic              gl_ack;
  logic              gl_rvalid;
  logic [DATA_W-1:0] gl_rdata;
  logic              clr_start = 1'b0;
  logic [DATA_W-1:0] clr_color = '0;
  logic              clr_busy;
  logic              clr_done;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_write_enabled;
  logic [DATA_W-1:0] ram_write_data;
  logic [DATA_W-1:0] ram_read_data = '0;

  always #5 clock = ~clock;

  fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(FB_WORDS), .RD_LATENCY(1), .MAX_STARVE(4)
  ) dut (
    .clock(clock), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr), .gl_wdata(gl_wdata),
    .gl_ack(gl_ack), .gl_rvalid(gl_rvalid), .gl_rdata(gl_rdata),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_address(ram_address), .ram_write_enabled(ram_write_enabled),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
  );

  // Synchronous single-port RAM, one cycle read latency.
  logic [DATA_W-1:0] mem [0:FB_WORDS-1];
  logic              ram_load = 1'b0;

  always @(posedge clock) begin
    if (ram_load) begin
      for (int i = 0; i < FB_WORDS; i++) mem[i] <= '0;
      mem[5]  <= 3'b011;
      mem[7]  <= 3'b101;
      mem[20] <= 3'b110;
    end else if (ram_address < 19'(FB_WORDS)) begin
      if (ram_write_enabled) mem[ram_address[16:0]] <= ram_write_data;
      ram_read_data <= mem[ram_address[16:0]];
    end else begin
      ram_read_data <= '0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Write-order monitor for the full-clear sequence.
  logic mon_clear = 1'b0;
  int   exp_next = 0;
  int   busy_cnt = 0;
  int   order_err = 0;
  int   done_cnt = 0;
  int   vrv_cnt = 0;
  logic inj_seen = 1'b0;

  always @(negedge clock) begin
    if (clr_done) done_cnt++;
    if (vid_rvalid) vrv_cnt++;
    if (!mon_clear) begin
      exp_next = 0;
      busy_cnt = 0;
    end else begin
      if (clr_busy) busy_cnt++;
      if (ram_write_enabled) begin
        if (32'(ram_address) == exp_next && ram_write_data == 3'b000) exp_next++;
        else if (32'(ram_address) == 50000 && ram_write_data == 3'b111 && !inj_seen) inj_seen = 1'b1;
        else order_err++;
      end
    end
  end

  typedef struct {
    logic              vr;
    logic [ADDR_W-1:0] va;
    logic              gr;
    logic              gw;
    logic [ADDR_W-1:0] ga;
    logic [DATA_W-1:0] gd;
    logic              e_va;
    logic              e_ga;
    logic [ADDR_W-1:0] e_ra;
    logic              e_rwe;
    logic [DATA_W-1:0] e_rwd;
    logic              e_vrv;
    logic [DATA_W-1:0] e_vrd;
    logic              e_grv;
    logic [DATA_W-1:0] e_grd;
  } vec_t;

  function automatic vec_t mk(
    input logic vr, input int va, input logic gr, input logic gw, input int ga, input int gd,
    input logic e_va, input logic e_ga, input int e_ra, input logic e_rwe, input int e_rwd,
    input logic e_vrv, input int e_vrd, input logic e_grv, input int e_grd);
    vec_t v;
    v.vr = vr;  v.va = ADDR_W'(va);  v.gr = gr;  v.gw = gw;
    v.ga = ADDR_W'(ga);  v.gd = DATA_W'(gd);
    v.e_va = e_va;  v.e_ga = e_ga;  v.e_ra = ADDR_W'(e_ra);  v.e_rwe = e_rwe;
    v.e_rwd = DATA_W'(e_rwd);  v.e_vrv = e_vrv;  v.e_vrd = DATA_W'(e_vrd);
    v.e_grv = e_grv;  v.e_grd = DATA_W'(e_grd);
    return v;
  endfunction

  vec_t vecs [0:18];

  logic got_done;
  logic injected;
  logic found;
  int   vrv_snap;
  int   done_snap;

  initial begin
    //            vr va  gr gw ga    gd  eva ega era  rwe rwd vrv vrd grv grd
    vecs[0]  = mk(0, 0,  0, 0, 0,    0,  0,  0,  0,    0, 0,  0,  0,  0,  0);
    vecs[1]  = mk(0, 0,  1, 1, 1000, 4,  0,  1,  0,    0, 0,  0,  0,  0,  0);
    vecs[2]  = mk(0, 0,  0, 0, 0,    0,  0,  0,  1000, 1, 4,  0,  0,  0,  0);
    vecs[3]  = mk(1, 5,  0, 0, 0,    0,  1,  0,  1000, 0, 0,  0,  0,  0,  0);
    vecs[4]  = mk(0, 0,  0, 0, 0,    0,  0,  0,  5,    0, 0,  0,  0,  0,  0);
    vecs[5]  = mk(0, 0,  0, 0, 0,    0,  0,  0,  5,    0, 0,  1,  3,  0,  0);
    vecs[6]  = mk(0, 0,  0, 0, 0,    0,  0,  0,  5,    0, 0,  0,  3,  0,  0);
    vecs[7]  = mk(1, 20, 1, 0, 7,    0,  1,  0,  5,    0, 0,  0,  3,  0,  0);
    vecs[8]  = mk(1, 20, 1, 0, 7,    0,  1,  0,  20,   0, 0,  0,  3,  0,  0);
    vecs[9]  = mk(1, 20, 1, 0, 7,    0,  1,  0,  20,   0, 0,  1,  6,  0,  0);
    vecs[10] = mk(1, 20, 1, 0, 7,    0,  1,  0,  20,   0, 0,  1,  6,  0,  0);
    vecs[11] = mk(1, 20, 1, 0, 7,    0,  0,  1,  20,   0, 0,  1,  6,  0,  0);
    vecs[12] = mk(1, 20, 0, 0, 0,    0,  1,  0,  7,    0, 0,  1,  6,  0,  0);
    vecs[13] = mk(0, 0,  0, 0, 0,    0,  0,  0,  20,   0, 0,  0,  6,  1,  5);
    vecs[14] = mk(0, 0,  0, 0, 0,    0,  0,  0,  20,   0, 0,  1,  6,  0,  5);
    vecs[15] = mk(1, 30, 1, 1, 9,    2,  1,  0,  20,   0, 0,  0,  6,  0,  5);
    vecs[16] = mk(0, 0,  1, 1, 9,    2,  0,  1,  30,   0, 0,  0,  6,  0,  5);
    vecs[17] = mk(0, 0,  0, 0, 0,    0,  0,  0,  9,    1, 2,  1,  0,  0,  5);
    vecs[18] = mk(0, 0,  0, 0, 0,    0,  0,  0,  9,    0, 0,  0,  0,  0,  5);

    // Reset state, with requests asserted to show acks are masked.
    ram_load = 1'b1;
    vid_req  = 1'b1;
    gl_req   = 1'b1;
    repeat (2) @(posedge clock);
    ram_load = 1'b0;
    #1;
    check("rst_vid_ack", 32'(vid_ack), 0);
    check("rst_gl_ack", 32'(gl_ack), 0);
    check("rst_ram_we", 32'(ram_write_enabled), 0);
    check("rst_ram_addr", 32'(ram_address), 0);
    check("rst_clr_busy", 32'(clr_busy), 0);
    check("rst_rvalid", 32'({vid_rvalid, gl_rvalid}), 0);
    vid_req = 1'b0;
    gl_req  = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i <= 18; i++) begin
      @(posedge clock);
      #1;
      vid_req = vecs[i].vr;  vid_addr = vecs[i].va;
      gl_req = vecs[i].gr;   gl_we = vecs[i].gw;
      gl_addr = vecs[i].ga;  gl_wdata = vecs[i].gd;
      @(negedge clock);
      check($sformatf("v%0d_vid_ack", i), 32'(vid_ack), 32'(vecs[i].e_va));
      check($sformatf("v%0d_gl_ack", i), 32'(gl_ack), 32'(vecs[i].e_ga));
      check($sformatf("v%0d_ram_addr", i), 32'(ram_address), 32'(vecs[i].e_ra));
      check($sformatf("v%0d_ram_we", i), 32'(ram_write_enabled), 32'(vecs[i].e_rwe));
      if (vecs[i].e_rwe)
        check($sformatf("v%0d_ram_wdata", i), 32'(ram_write_data), 32'(vecs[i].e_rwd));
      check($sformatf("v%0d_vid_rvalid", i), 32'(vid_rvalid), 32'(vecs[i].e_vrv));
      check($sformatf("v%0d_vid_rdata", i), 32'(vid_rdata), 32'(vecs[i].e_vrd));
      check($sformatf("v%0d_gl_rvalid", i), 32'(gl_rvalid), 32'(vecs[i].e_grv));
      check($sformatf("v%0d_gl_rdata", i), 32'(gl_rdata), 32'(vecs[i].e_grd));
    end

    // Full clear with a game write injected at clr_addr=100 and a restart attempt mid-clear.
    @(posedge clock);
    #1;
    vid_req = 1'b0;  gl_req = 1'b0;
    mon_clear = 1'b1;
    clr_color = 3'b000;
    clr_start = 1'b1;
    @(posedge clock);
    #1;
    clr_start = 1'b0;
    check("clr_busy_start", 32'(clr_busy), 1);
    got_done = 1'b0;
    injected = 1'b0;
    for (int c = 0; c < 80000 && !got_done; c++) begin
      @(negedge clock);
      if (clr_done) begin
        got_done = 1'b1;
      end else if (!injected && ram_write_enabled && ram_address == 19'd99) begin
        gl_req = 1'b1;  gl_we = 1'b1;  gl_addr = 19'd50000;  gl_wdata = 3'b111;
        #1;
        check("inject_gl_ack", 32'(gl_ack), 1);
        injected = 1'b1;
        @(posedge clock);
        #1;
        gl_req = 1'b0;
        check("inject_ram_addr", 32'(ram_address), 50000);
        check("inject_ram_wdata", 32'(ram_write_data), 7);
      end else if (c == 1000) begin
        clr_color = 3'b111;
        clr_start = 1'b1;
        @(posedge clock);
        #1;
        clr_start = 1'b0;
        clr_color = 3'b000;
      end
    end
    check("clr_done_seen", 32'(got_done), 1);
    @(negedge clock);
    check("clr_next_addr", 32'(exp_next), FB_WORDS);
    check("clr_order_err", 32'(order_err), 0);
    check("clr_inject_seen", 32'(inj_seen), 1);
    check("clr_busy_cycles", 32'(busy_cnt), FB_WORDS + 1);
    check("clr_done_count", 32'(done_cnt), 1);
    check("clr_busy_after", 32'(clr_busy), 0);
    check("mem_0", 32'(mem[0]), 0);
    check("mem_50000", 32'(mem[50000]), 0);
    check("mem_last", 32'(mem[FB_WORDS-1]), 0);

    // Reset during a clear with a video read in flight.
    mon_clear = 1'b0;
    @(posedge clock);
    #1;
    clr_color = 3'b010;
    clr_start = 1'b1;
    @(posedge clock);
    #1;
    clr_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clock);
      if (ram_write_enabled && ram_address == 19'd299) begin
        found = 1'b1;
        vid_req = 1'b1;
        vid_addr = 19'd5;
      end
    end
    check("reach_addr_300", 32'(found), 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("mid_vid_ack", 32'(vid_ack), 0);
    check("mid_ram", 32'({ram_address, ram_write_enabled, ram_write_data}), 0);
    check("mid_clr", 32'({clr_busy, clr_done}), 0);
    check("mid_rvalid", 32'({vid_rvalid, gl_rvalid}), 0);
    check("mid_rdata", 32'({vid_rdata, gl_rdata}), 0);
    vrv_snap  = vrv_cnt;
    done_snap = done_cnt;
    vid_req = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("post_rst_no_rvalid", 32'(vrv_cnt - vrv_snap), 0);
    check("post_rst_no_done", 32'(done_cnt - done_snap), 0);
    check("post_rst_busy", 32'(clr_busy), 0);
    @(posedge clock);
    #1;
    clr_color = 3'b011;
    clr_start = 1'b1;
    @(posedge clock);
    #1;
    clr_start = 1'b0;
    check("restart_busy", 32'(clr_busy), 1);
    @(posedge clock);
    #1;
    check("restart_addr0", 32'(ram_address), 0);
    check("restart_we", 32'(ram_write_enabled), 1);
    check("restart_color", 32'(ram_write_data), 3);
    @(posedge clock);
    #1;
    check("restart_addr1", 32'(ram_address), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
